sequence_scheduler: RTL and testbench
=====================================

// Module: sequence_scheduler
// PURPOSE
//   Shares one WIDTH-bit up-counting sequence engine between two requesters.
//   Each requester asks for one run (start value, length); a round-robin arbiter grants the engine.
//   An FSM loads the start value, emits LEN+1 consecutive counts, then pulses done to the owner.
//   Sits between the control logic and the downstream consumer of the count stream.
// PARAMETERS
//   WIDTH  4  width of count, start and len fields
// PORTS
//   clk          in   1      rising-edge clock, single clock domain
//   reset_n      in   1      asynchronous, active-low reset
//   req          in   2      req[i]=1: requester i wants a run; sampled only in IDLE
//   start0       in   WIDTH  first count value for requester 0
//   len0         in   WIDTH  requester 0 run length minus 1 (0 -> 1 value, 15 -> 16 values)
//   start1       in   WIDTH  first count value for requester 1
//   len1         in   WIDTH  requester 1 run length minus 1
//   hold         in   1      stall: freeze the count, no value emitted this cycle
//   count        out  WIDTH  current sequence value
//   count_valid  out  1      count is a new emitted value this cycle
//   grant        out  2      one-hot owner of the engine, high for the whole RUN
//   done         out  2      one-cycle pulse to the owner after its last value
//   busy         out  1      state != IDLE
// BEHAVIOUR
//   Reset (reset_n=0, asynchronous) sets:
//     state=IDLE, count=0, count_valid=0, grant=0, done=0, busy=0
//     remaining=0, last_owner=1 (so requester 0 wins the first tie)
//     Reset mid-run aborts the run immediately; no done pulse is given.
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE:
//     If req==0, stay in IDLE.
//     If exactly one req bit is set, that requester wins.
//     If req==2'b11, the requester != last_owner wins.
//     At the next edge: state=RUN, grant=onehot(win), last_owner=win.
//     Also at that edge: count=start_win, remaining=len_win.
//     start/len are captured on this edge; later changes are ignored.
//   RUN:
//     count_valid = !hold (combinational from state and hold).
//     With hold=0 and remaining!=0: count<=count+1 (mod 2^WIDTH, so 15 wraps to 0), remaining<=remaining-1.
//     With hold=0 and remaining==0: the current value is the last one; next state=DONE.
//     With hold=1: count and remaining do not change; count_valid=0.
//     Run length: exactly len+1 valid cycles, first value start, then start+1, ... (mod 2^WIDTH).
//     req is ignored during RUN; deasserting it does not abort the run.
//   DONE:
//     One cycle. grant=0, count_valid=0, done[owner]=1, count holds the last value.
//     Next state=IDLE.
//   Latency: req seen in IDLE cycle T -> first valid count in cycle T+1.
//   Turnaround: minimum 2 dead cycles (DONE, IDLE) between back-to-back runs.
//   grant and done are never both nonzero; at most one bit of each is set.
// TESTING
//   1. Reset release, req=0 for 10 cycles -> count=0, count_valid=0, grant=0, busy=0.
//   2. req=01, start0=3, len0=4 -> counts 3,4,5,6,7 on 5 consecutive valid cycles,
//      then done=01 for 1 cycle, then IDLE.
//   3. req=10, start1=14, len1=3 -> counts 14,15,0,1 (wrap), then done=10.
//   4. req=11 held: -> grants alternate 01,10,01; after reset the first grant is 01.
//   5. In RUN, start0=0, len0=2, hold=1 on cycles 2-3 -> valid counts 0,1,2 only,
//      no valid and no count change while hold=1.
//   6. reset_n=0 mid-run at count=5 -> count=0, grant=0, done=0 at once;
//      req=01 after release wins, and its run starts fresh.

Source files
------------

// File: rtl/sequence_scheduler.sv
// Round-robin shared up-counter: two requesters, one sequence engine.
// Ports: clk, reset_n (async low), req[1:0], start0/len0, start1/len1,
//        hold -> count, count_valid, grant[1:0], done[1:0], busy.
module sequence_scheduler #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] start0,
   input  logic [WIDTH-1:0] len0,
   input  logic [WIDTH-1:0] start1,
   input  logic [WIDTH-1:0] len1,
   input  logic             hold,
   output logic [WIDTH-1:0] count,
   output logic             count_valid,
   output logic [1:0]       grant,
   output logic [1:0]       done,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   state_e           state_q;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] rem_q;
   logic [1:0]       grant_q;
   logic [1:0]       done_q;
   logic             busy_q;
   logic             last_q;

   logic             win_d;
   logic             any_req;
   logic [WIDTH-1:0] start_d;
   logic [WIDTH-1:0] len_d;
   logic [1:0]       grant_d;
   logic             step;
   logic             last_val;

   // Arbitration: a tie goes to whoever did not own the last run.
   always_comb begin
      win_d   = 1'b0;
      any_req = 1'b1;
      case (req)
         2'b01:   win_d = 1'b0;
         2'b10:   win_d = 1'b1;
         2'b11:   win_d = ~last_q;
         default: any_req = 1'b0;
      endcase
   end

   always_comb begin
      start_d = win_d ? start1 : start0;
      len_d   = win_d ? len1 : len0;
      grant_d = win_d ? 2'b10 : 2'b01;
   end

   // A value is emitted in every unstalled RUN cycle.
   assign step     = (state_q == S_RUN) && !hold;
   assign last_val = (rem_q == ZERO);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         count_q <= ZERO;
         rem_q   <= ZERO;
         grant_q <= 2'b00;
         done_q  <= 2'b00;
         busy_q  <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 2'b00;
               if (any_req) begin
                  state_q <= S_RUN;
                  count_q <= start_d;
                  rem_q   <= len_d;
                  grant_q <= grant_d;
                  last_q  <= win_d;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               if (step) begin
                  if (last_val) begin
                     // count keeps the final value through DONE
                     state_q <= S_DONE;
                     done_q  <= grant_q;
                     grant_q <= 2'b00;
                  end else begin
                     count_q <= count_q + ONE;
                     rem_q   <= rem_q - ONE;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 2'b00;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               grant_q <= 2'b00;
               done_q  <= 2'b00;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign count       = count_q;
   assign count_valid = step;
   assign grant       = grant_q;
   assign done        = done_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_sequence_scheduler.sv
// Directed bench for sequence_scheduler: cycle tables plus
// hand-written arbitration and mid-run reset sequences.
module tb_sequence_scheduler;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] req;
   logic [3:0] start0, len0, start1, len1;
   logic       hold;
   logic [3:0] count;
   logic       count_valid;
   logic [1:0] grant, done;
   logic       busy;

   int checks = 0;
   int errors = 0;

   sequence_scheduler #(.WIDTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .req(req),
      .start0(start0), .len0(len0),
      .start1(start1), .len1(len1),
      .hold(hold), .count(count), .count_valid(count_valid),
      .grant(grant), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] req;
      logic [3:0] s0, l0, s1, l1;
      logic       hold;
      logic [3:0] e_count;
      logic       e_valid;
      logic [1:0] e_grant;
      logic [1:0] e_done;
      logic       e_busy;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [1:0] r, input logic [3:0] s0,
                      input logic [3:0] l0, input logic [3:0] s1,
                      input logic [3:0] l1, input logic h,
                      input logic [3:0] ec, input logic ev,
                      input logic [1:0] eg, input logic [1:0] ed,
                      input logic eb);
      vec_t v;
      v.req = r; v.s0 = s0; v.l0 = l0; v.s1 = s1; v.l1 = l1;
      v.hold = h; v.e_count = ec; v.e_valid = ev;
      v.e_grant = eg; v.e_done = ed; v.e_busy = eb;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req = 2'b00; hold = 1'b0;
      start0 = 4'd0; len0 = 4'd0; start1 = 4'd0; len1 = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   int excl_bad = 0;
   always @(negedge clk)
      if (reset_n && ((grant != 0 && done != 0) ||
          $countones(grant) > 1 || $countones(done) > 1))
         excl_bad++;

   initial begin
      logic [1:0] seen[3];
      int n;
      int ok;

      // test 2: start0=3 len0=4 -> 3..7 then done=01
      add(2'b01, 3, 4, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0);
      add(2'b00, 9, 9, 0, 0, 0,  3, 1, 2'b01, 2'b00, 1);
      add(2'b00, 9, 9, 0, 0, 0,  4, 1, 2'b01, 2'b00, 1);
      add(2'b00, 9, 9, 0, 0, 0,  5, 1, 2'b01, 2'b00, 1);
      add(2'b00, 9, 9, 0, 0, 0,  6, 1, 2'b01, 2'b00, 1);
      add(2'b00, 9, 9, 0, 0, 0,  7, 1, 2'b01, 2'b00, 1);
      add(2'b00, 9, 9, 0, 0, 0,  7, 0, 2'b00, 2'b01, 1);
      // test 3: start1=14 len1=3 -> 14,15,0,1 (wrap)
      add(2'b10, 0, 0, 14, 3, 0, 7, 0, 2'b00, 2'b00, 0);
      add(2'b10, 0, 0, 5, 9, 0,  14, 1, 2'b10, 2'b00, 1);
      add(2'b10, 0, 0, 5, 9, 0,  15, 1, 2'b10, 2'b00, 1);
      add(2'b00, 0, 0, 5, 9, 0,  0, 1, 2'b10, 2'b00, 1);
      add(2'b00, 0, 0, 5, 9, 0,  1, 1, 2'b10, 2'b00, 1);
      add(2'b00, 0, 0, 5, 9, 0,  1, 0, 2'b00, 2'b10, 1);
      // test 5: start0=0 len0=2, hold on run cycles 2-3
      add(2'b01, 0, 2, 0, 0, 0,  1, 0, 2'b00, 2'b00, 0);
      add(2'b00, 0, 2, 0, 0, 0,  0, 1, 2'b01, 2'b00, 1);
      add(2'b00, 0, 2, 0, 0, 1,  1, 0, 2'b01, 2'b00, 1);
      add(2'b00, 0, 2, 0, 0, 1,  1, 0, 2'b01, 2'b00, 1);
      add(2'b00, 0, 2, 0, 0, 0,  1, 1, 2'b01, 2'b00, 1);
      add(2'b00, 0, 2, 0, 0, 0,  2, 1, 2'b01, 2'b00, 1);
      add(2'b00, 0, 2, 0, 0, 0,  2, 0, 2'b00, 2'b01, 1);
      add(2'b00, 0, 2, 0, 0, 0,  2, 0, 2'b00, 2'b00, 0);

      do_reset();

      // test 1: idle after reset
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_count", count, 0);
         chk("idle_valid", count_valid, 0);
         chk("idle_grant", grant, 0);
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         @(posedge clk);
         #1;
      end

      foreach (tbl[i]) begin
         req = tbl[i].req; hold = tbl[i].hold;
         start0 = tbl[i].s0; len0 = tbl[i].l0;
         start1 = tbl[i].s1; len1 = tbl[i].l1;
         @(negedge clk);
         chk($sformatf("v%0d_count", i), count, tbl[i].e_count);
         chk($sformatf("v%0d_valid", i), count_valid, tbl[i].e_valid);
         chk($sformatf("v%0d_grant", i), grant, tbl[i].e_grant);
         chk($sformatf("v%0d_done", i), done, tbl[i].e_done);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
         @(posedge clk);
         #1;
      end

      // test 6: reset mid-run at count=5
      req = 2'b01; start0 = 4'd2; len0 = 4'd7; hold = 1'b0;
      @(posedge clk);
      #1;
      req = 2'b00;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (count == 4'd5 && count_valid) ok = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("rst_reach5", ok, 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_grant", grant, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", count_valid, 0);
      @(negedge clk);
      reset_n = 1'b1;
      req = 2'b01; start0 = 4'd9; len0 = 4'd1;
      @(negedge clk);
      req = 2'b00;
      chk("rst_run0_count", count, 9);
      chk("rst_run0_grant", grant, 1);
      chk("rst_run0_valid", count_valid, 1);
      @(negedge clk);
      chk("rst_run1_count", count, 10);
      @(negedge clk);
      chk("rst_run_done", done, 1);
      chk("rst_run_done_cnt", count, 10);

      // test 4: req=11 held after reset -> grants 01,10,01
      do_reset();
      req = 2'b11; len0 = 4'd0; len1 = 4'd0;
      start0 = 4'd4; start1 = 4'd8;
      n = 0;
      for (int i = 0; i < 30 && n < 3; i++) begin
         @(negedge clk);
         if (grant != 2'b00) begin
            seen[n] = grant;
            n++;
         end
      end
      req = 2'b00;
      chk("rr_num", n, 3);
      if (n == 3) begin
         chk("rr_g0", seen[0], 1);
         chk("rr_g1", seen[1], 2);
         chk("rr_g2", seen[2], 1);
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("excl", excl_bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
